// File: rtl/ram_dp_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, registered read
// latency of 1 or 2, selectable read-during-write policy and a whole-array clear engine.
module ram_dp_be #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  output logic                      busy,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  // Handshake: a request is accepted in any cycle where its enable is high and
  // busy is low; there is no backpressure, so requests seen during busy are lost.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    clear_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clear_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        clear_we = 1'b1;
        ptr_d    = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  logic wr_accept;
  logic rd_accept;

  assign wr_accept = wr_en & ~busy;
  assign rd_accept = rd_en & ~busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array writes are suppressed while rst is held so the sweep starts cleanly at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) begin
        mem[ptr_q] <= CLEAR_VALUE;
      end else if (wr_accept) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_sample;

  always_comb begin
    old_word    = mem[rd_addr];
    merged_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        merged_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    rd_sample = old_word;
    if ((RDW_MODE == 1) && wr_accept && (wr_addr == rd_addr)) begin
      rd_sample = merged_word;
    end
  end

  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_accept;
          if (rd_accept) begin
            s1_data_q <= rd_sample;
          end
        end
      end

      assign pipe_valid = s1_valid_q;
      assign pipe_data  = s1_data_q;
    end else begin : g_lat1
      assign pipe_valid = rd_accept;
      assign pipe_data  = rd_sample;
    end
  endgenerate

  // Output register only loads on a valid beat so rd_data holds between reads.
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pipe_valid;
      if (pipe_valid) begin
        rd_data_q <= pipe_data;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
